// File: rtl/perm_oser_pkg.sv
// Shared types and constants for the Keccak permutation output serialiser.
package perm_oser_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DST  = 3'd2,
    LEN  = 3'd3,
    DATA = 3'd4,
    CHK  = 3'd5
  } oser_st_t;

  localparam logic [7:0] NOC_IDLE_BYTE  = 8'h00;
  localparam int         BYTES_PER_WORD = 8;

  // One buffered result word plus its frame-start marker.
  typedef struct packed {
    logic        first;
    logic [63:0] d;
  } fifo_ent_t;

endpackage

// File: rtl/perm_oser_fifo.sv
// Single-clock word FIFO; the head entry is visible combinationally on dout.
module perm_oser_fifo
  import perm_oser_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  fifo_ent_t     din,
  output fifo_ent_t     dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_ent_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage write.
  // NOTE: the storage array is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/perm_out_ser.sv
// Keccak permutation output serialiser: buffers 64-bit result words and sends each
// complete frame as one NOC packet (header, dest, length, little-endian data bytes).
// Optional trailing XOR checksum byte is enabled by defining PERM_OSER_CHKSUM_EN.
module perm_out_ser
  import perm_oser_pkg::*;
#(
  parameter int         WORDS    = 25,
  parameter int         DEPTH    = 32,
  parameter logic [7:0] HDR_CODE = 8'h05
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushin,
  input  logic        firstin,
  input  logic [63:0] din,
  output logic        stopin,
  input  logic [7:0]  dest_id,
  output logic        noc_from_dev_ctl,
  output logic [7:0]  noc_from_dev_data,
  output logic        err_ovf,
  output logic        err_sync
);

  localparam int         CW       = $clog2(DEPTH + 1);
  localparam logic [7:0] LEN_BYTE = 8'(WORDS * BYTES_PER_WORD);

  oser_st_t      r_state;
  oser_st_t      w_next;
  fifo_ent_t     w_fifo_din;
  fifo_ent_t     w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ready;
  logic          w_sync_drop;
  logic          w_last_byte;
  logic          w_last_word;
  logic          w_ctl;
  logic [7:0]    w_data;
  logic [2:0]    r_byte;
  logic [4:0]    r_word;
  logic [7:0]    r_dest;
  logic          r_ctl;
  logic [7:0]    r_data;
  logic          r_err_ovf;
  logic          r_err_sync;
`ifdef PERM_OSER_CHKSUM_EN
  logic [7:0]    r_chk;
`endif

  assign stopin     = w_full;
  assign w_push     = pushin && !stopin;
  assign w_fifo_din = '{first: firstin, d: din};

  perm_oser_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_ready     = !w_empty && w_head.first && (w_count >= CW'(WORDS));
  assign w_last_byte = (r_byte == 3'd7);
  assign w_last_word = (r_word == 5'(WORDS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_ready) w_next = HDR;
      HDR:  w_next = DST;
      DST:  w_next = LEN;
      LEN:  w_next = DATA;
      DATA: begin
        if (w_last_byte && w_last_word) begin
`ifdef PERM_OSER_CHKSUM_EN
          w_next = CHK;
`else
          w_next = IDLE;
`endif
        end
      end
`ifdef PERM_OSER_CHKSUM_EN
      CHK:  w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Per-state byte mux and FIFO pop control.
  always_comb begin
    w_ctl       = 1'b1;
    w_data      = NOC_IDLE_BYTE;
    w_pop       = 1'b0;
    w_sync_drop = 1'b0;
    case (r_state)
      IDLE: begin
        // A head without the frame marker can never start a packet: discard it.
        if (!w_empty && !w_head.first) begin
          w_pop       = 1'b1;
          w_sync_drop = 1'b1;
        end
      end
      HDR: begin
        w_ctl  = 1'b1;
        w_data = HDR_CODE;
      end
      DST: begin
        w_ctl  = 1'b0;
        w_data = r_dest;
      end
      LEN: begin
        w_ctl  = 1'b0;
        w_data = LEN_BYTE;
      end
      DATA: begin
        w_ctl  = 1'b0;
        w_data = w_head.d[{r_byte, 3'b000} +: 8];
        w_pop  = w_last_byte;
      end
`ifdef PERM_OSER_CHKSUM_EN
      CHK: begin
        w_ctl  = 1'b0;
        w_data = r_chk;
      end
`endif
      default: begin
        w_ctl  = 1'b1;
        w_data = NOC_IDLE_BYTE;
      end
    endcase
  end

  // Byte and word counters, active only while streaming DATA.
  always_ff @(posedge clk) begin
    if (reset || r_state != DATA) begin
      r_byte <= '0;
      r_word <= '0;
    end else begin
      r_byte <= r_byte + 3'd1;
      if (w_last_byte) r_word <= r_word + 5'd1;
    end
  end

  // Destination id captured during the header cycle for the following DST byte.
  always_ff @(posedge clk) begin
    if (reset)                r_dest <= '0;
    else if (r_state == HDR)  r_dest <= dest_id;
  end

`ifdef PERM_OSER_CHKSUM_EN
  // XOR of all data bytes of the current packet.
  always_ff @(posedge clk) begin
    if (reset || r_state == HDR) r_chk <= '0;
    else if (r_state == DATA)    r_chk <= r_chk ^ w_data;
  end
`endif

  // Registered NOC outputs; reset drives the idle pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl  <= 1'b1;
      r_data <= NOC_IDLE_BYTE;
    end else begin
      r_ctl  <= w_ctl;
      r_data <= w_data;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_ovf  <= 1'b0;
      r_err_sync <= 1'b0;
    end else begin
      if (pushin && stopin) r_err_ovf  <= 1'b1;
      if (w_sync_drop)      r_err_sync <= 1'b1;
    end
  end

  assign noc_from_dev_ctl  = r_ctl;
  assign noc_from_dev_data = r_data;
  assign err_ovf           = r_err_ovf;
  assign err_sync          = r_err_sync;

endmodule
